// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Registered three-way arbiter for the shared memory bus.
//               Grants ownership to the object processor, blitter or GPU
//               via one-hot bus-acknowledge outputs and holds ownership
//               while a memory cycle is in flight (mreq seen, ack pending).
//               Optional macro ARB_BURST_LIMIT_EN adds a per-tenure ack
//               counter that forces release after BURST_MAX acks when
//               another requester is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int BURST_MAX   = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       op_req,
    input  logic       blit_breq,
    input  logic       gpu_breq,
    input  logic       blit_hipri,
    input  logic       mreq,
    input  logic       ack,
    output logic       op_back,
    output logic       blit_back,
    output logic       gpu_back,
    output logic [1:0] owner,
    output logic       bus_idle
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_OWN  = 2'd1;
    localparam logic [1:0] c_ST_TURN = 2'd2;

    localparam logic [1:0] c_OWN_NONE = 2'd0;
    localparam logic [1:0] c_OWN_OP   = 2'd1;
    localparam logic [1:0] c_OWN_BLIT = 2'd2;
    localparam logic [1:0] c_OWN_GPU  = 2'd3;

    localparam logic [2:0] c_TURN_LAST = 3'(TURN_CYCLES);

    // Reject out-of-range configurations at elaboration time.
    if (BURST_MAX < 1 || BURST_MAX > 255 || TURN_CYCLES < 1 || TURN_CYCLES > 7) begin : g_param_check
        $error("bus_arbiter: BURST_MAX or TURN_CYCLES out of range");
    end

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic       r_inflight;
    logic [2:0] r_turn_cnt;
    logic       r_prefer_gpu;

    logic [1:0] w_state_nxt;
    logic [1:0] w_owner_nxt;
    logic [2:0] w_turn_cnt_nxt;
    logic       w_prefer_gpu_nxt;
    logic       w_inflight_nxt;
    logic [1:0] w_winner;
    logic       w_grant;
    logic       w_owner_req;
    logic       w_preempt;
    logic       w_safe;
    logic       w_release;
    logic       w_burst_release;

    // Priority / round-robin choice among the current requesters.
    always_comb begin
        w_winner = c_OWN_NONE;
        if (op_req) begin
            w_winner = c_OWN_OP;
        end else if (blit_hipri && blit_breq) begin
            w_winner = c_OWN_BLIT;
        end else if (blit_breq && gpu_breq) begin
            w_winner = r_prefer_gpu ? c_OWN_GPU : c_OWN_BLIT;
        end else if (blit_breq) begin
            w_winner = c_OWN_BLIT;
        end else if (gpu_breq) begin
            w_winner = c_OWN_GPU;
        end
    end

    // Request line of whoever currently owns the bus.
    always_comb begin
        w_owner_req = 1'b0;
        case (r_owner)
            c_OWN_OP:   w_owner_req = op_req;
            c_OWN_BLIT: w_owner_req = blit_breq;
            c_OWN_GPU:  w_owner_req = gpu_breq;
            default:    w_owner_req = 1'b0;
        endcase
    end

    // Blitter and GPU owner codes both have bit 1 set, so that bit flags
    // an owner the OP is allowed to preempt.
    assign w_preempt = r_owner[1] & op_req;

    // Nothing outstanding, or the outstanding cycle completes this cycle.
    assign w_safe = (~r_inflight & ~mreq) | ack;

    assign w_release = (r_state == c_ST_OWN) & w_safe &
                       (~w_owner_req | w_preempt | w_burst_release);

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] c_BURST_MAX = 8'(BURST_MAX);

    logic [7:0] r_burst_cnt;
    logic [7:0] w_burst_cnt_inc;
    logic       w_other_req;

    // Anyone other than the current owner asking for the bus.
    always_comb begin
        w_other_req = 1'b0;
        case (r_owner)
            c_OWN_OP:   w_other_req = blit_breq | gpu_breq;
            c_OWN_BLIT: w_other_req = op_req | gpu_breq;
            c_OWN_GPU:  w_other_req = op_req | blit_breq;
            default:    w_other_req = 1'b0;
        endcase
    end

    // Counter saturates at the limit so an uncontested owner keeps the bus.
    assign w_burst_cnt_inc = (r_burst_cnt == c_BURST_MAX) ? r_burst_cnt
                                                          : r_burst_cnt + 8'd1;
    assign w_burst_release = (r_state == c_ST_OWN) & ack &
                             (w_burst_cnt_inc == c_BURST_MAX) & w_other_req;

    // Count acks within the current tenure; cleared outside OWN and on release.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_burst_cnt <= 8'd0;
        end else if (r_state != c_ST_OWN || w_release) begin
            r_burst_cnt <= 8'd0;
        end else if (ack) begin
            r_burst_cnt <= w_burst_cnt_inc;
        end
    end
`else
    assign w_burst_release = 1'b0;
`endif

    // Next-state, next-owner and turnaround counter logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_turn_cnt_nxt = r_turn_cnt;
        w_grant        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_owner_nxt = c_OWN_NONE;
                if (w_winner != c_OWN_NONE) begin
                    w_state_nxt = c_ST_OWN;
                    w_owner_nxt = w_winner;
                    w_grant     = 1'b1;
                end
            end
            c_ST_OWN: begin
                if (w_release) begin
                    w_state_nxt    = c_ST_TURN;
                    w_owner_nxt    = c_OWN_NONE;
                    w_turn_cnt_nxt = 3'd1;
                end
            end
            c_ST_TURN: begin
                w_owner_nxt = c_OWN_NONE;
                if (r_turn_cnt >= c_TURN_LAST) begin
                    w_turn_cnt_nxt = 3'd0;
                    if (w_winner != c_OWN_NONE) begin
                        w_state_nxt = c_ST_OWN;
                        w_owner_nxt = w_winner;
                        w_grant     = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else begin
                    w_turn_cnt_nxt = r_turn_cnt + 3'd1;
                end
            end
            default: begin
                w_state_nxt    = c_ST_IDLE;
                w_owner_nxt    = c_OWN_NONE;
                w_turn_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Round-robin pointer and in-flight tracking; ack is only meaningful in OWN.
    always_comb begin
        w_prefer_gpu_nxt = r_prefer_gpu;
        if (w_grant && w_owner_nxt == c_OWN_BLIT) begin
            w_prefer_gpu_nxt = 1'b1;
        end else if (w_grant && w_owner_nxt == c_OWN_GPU) begin
            w_prefer_gpu_nxt = 1'b0;
        end

        w_inflight_nxt = r_inflight;
        if (r_state == c_ST_OWN) begin
            if (ack) begin
                w_inflight_nxt = 1'b0;
            end else if (mreq) begin
                w_inflight_nxt = 1'b1;
            end
        end
    end

    // State registers; reset drops any grant regardless of cycles in flight.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_OWN_NONE;
            r_inflight   <= 1'b0;
            r_turn_cnt   <= 3'd0;
            r_prefer_gpu <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_inflight   <= w_inflight_nxt;
            r_turn_cnt   <= w_turn_cnt_nxt;
            r_prefer_gpu <= w_prefer_gpu_nxt;
        end
    end

    // Outputs decode straight from the owner register, so they are one-hot
    // by construction and carry no combinational path from the inputs.
    assign op_back   = (r_owner == c_OWN_OP);
    assign blit_back = (r_owner == c_OWN_BLIT);
    assign gpu_back  = (r_owner == c_OWN_GPU);
    assign owner     = r_owner;
    assign bus_idle  = (r_owner == c_OWN_NONE);

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Registered three-way arbiter for the shared memory bus in Tom. It grants bus ownership to the object processor, the blitter and the GPU via one-hot bus-acknowledge outputs (`op_back`, `blit_back`, `gpu_back`). The memory control logic of the owning requester gates its tri-state address, width and control drivers with its `*_back`. The arbiter tracks in-flight memory cycles so that ownership never changes between `mreq` and its `ack`.

## Interface
Parameters:
- `BURST_MAX`, default 8: acks per tenure before forced release when another requester waits (only used with `ARB_BURST_LIMIT_EN`); range 1–255.
- `TURN_CYCLES`, default 1: dead cycles with no bus grant between tenures; range 1–7.

Ports:
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_req`  in  1  object processor bus request; highest priority.
- `blit_breq`  in  1  blitter bus request.
- `gpu_breq`  in  1  GPU bus request.
- `blit_hipri`  in  1  when high, the blitter beats the GPU outright instead of round-robin.
- `mreq`  in  1  resolved bus memory-cycle request from the current owner.
- `ack`  in  1  memory controller cycle-complete strobe, one cycle per access.
- `op_back`  out  1  object processor owns the bus.
- `blit_back`  out  1  blitter owns the bus.
- `gpu_back`  out  1  GPU owns the bus.
- `owner`  out  2  0 = none, 1 = OP, 2 = blitter, 3 = GPU; always consistent with the `*_back` outputs.
- `bus_idle`  out  1  high when no `*_back` is asserted.

## Operation
- Reset: all `*_back` = 0, `owner` = 0, `bus_idle` = 1.
  - State becomes IDLE; in-flight flag, burst counter and round-robin pointer are cleared.
  - After reset the pointer favours the blitter.
  - Reset mid-tenure drops the grant on the next edge, regardless of any cycle in flight.
- States: IDLE, OWN, TURN.
- Arbitration is evaluated in IDLE and in the last TURN cycle:
  - `op_req` wins first.
  - Otherwise, if `blit_hipri` & `blit_breq`, the blitter wins.
  - Otherwise, if both `blit_breq` and `gpu_breq` are high, the winner is the one not granted last.
  - Otherwise, the single requester wins.
  - A winner moves the state to OWN. With no requester, the state goes to (or stays in) IDLE.
- Round-robin pointer: updated whenever the blitter or GPU is granted. An OP grant leaves it unchanged.
- In-flight flag: set when owner state & `mreq` & ~`ack`; cleared on `ack`.
  - A cycle is idle-safe when (flag = 0 & `mreq` = 0) or `ack` = 1.
- OWN release happens only on an idle-safe cycle, when any of the following holds:
  - the owner's request is low;
  - the owner is not the OP and `op_req` is high (OP preemption);
  - the burst limit is reached (see Configuration).
- On release the state goes to TURN, all backs drop on the next edge and the burst counter clears.
- TURN: lasts `TURN_CYCLES` cycles, counted by a 3-bit counter. Requests that drop during TURN are simply not considered.
- A requester dropping its request and re-asserting it in the same tenure is treated as a release if the drop landed on an idle-safe cycle.
- The `ack` input is ignored when no grant is active.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Grant latency from IDLE: request sampled high at edge N → `*_back` high after edge N+1 (1 cycle).
- Release at cycle T (back still high in T):
  - all backs low during T+1 … T+`TURN_CYCLES`;
  - arbitration in the last TURN cycle;
  - new back high at T+`TURN_CYCLES`+1.
- Preemption latency: `op_req` rises during a GPU cycle that acks at cycle A → `gpu_back` low at A+1, `op_back` high at A+1+`TURN_CYCLES`.
- Simultaneous `ack` and owner request drop in the same cycle → release in that cycle.
- At most one `*_back` is high in any cycle, ever.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - an 8-bit counter counts `ack`s during the tenure;
  - when the count reaches `BURST_MAX` and any other requester is high, release happens on that `ack`;
  - with no other requester waiting, the counter saturates and the owner keeps the bus.
- `ARB_BURST_LIMIT_EN` undefined: no counter. The owner keeps the bus until its request drops, or until OP preemption for blitter/GPU owners.

## Test plan
- Reset held 2 cycles with `blit_breq` = 1 → all backs 0, `owner` = 0 during reset; `blit_back` = 1 and `owner` = 2 one cycle after reset deasserts.
- `blit_breq` and `gpu_breq` both held, each tenure ended by dropping the request for one cycle (`TURN_CYCLES` = 1) → grants alternate blitter, GPU, blitter, with exactly one dead cycle between tenures.
- Blitter owns the bus, `mreq` = 1, `op_req` rises, `ack` arrives 3 cycles later → `blit_back` stays high until that `ack`, low the next cycle, `op_back` high 2 cycles after the `ack`.
- `blit_hipri` = 1 with both `blit_breq` and `gpu_breq` high for 4 tenures → blitter granted all 4 times.
- With `ARB_BURST_LIMIT_EN`, `BURST_MAX` = 4, GPU owner issuing back-to-back acks while `blit_breq` = 1 → `gpu_back` low the cycle after the 4th `ack`, `blit_back` high after 1 dead cycle. With `blit_breq` = 0 instead, the GPU keeps the bus past 10 acks.
- Random `mreq`/`ack` traffic with all requesters toggling, checked by assertion → never more than one back high, and no ownership change while the in-flight flag is set.
